// File: rtl/mux_pkg.sv
// Shared constants and width helpers for the rr_mux arbitrated multiplexer.
package mux_pkg;

  localparam int MODE_FIXED = 0;
  localparam int MODE_RR    = 1;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < n) r++;
    end
    return r;
  endfunction

  // Select field is never narrower than one bit, even for a single-bit index space.
  function automatic int sel_width(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// One-hot arbiter for rr_mux: fixed-priority or round-robin search starting at ptr.
// Packet lock (stay on a channel until its last beat) is built when RR_MUX_LOCK_EN is defined.
module rr_arbiter
  import mux_pkg::*;
#(
  parameter  int NUM_IN = 4,
  parameter  int MODE   = MODE_RR,
  localparam int SEL_W  = sel_width(NUM_IN)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NUM_IN-1:0] req,
  input  logic              advance,
`ifdef RR_MUX_LOCK_EN
  input  logic              last,
`endif
  output logic [NUM_IN-1:0] grant,
  output logic [SEL_W-1:0]  grant_idx
);

  logic [SEL_W-1:0]  r_ptr;
  logic [SEL_W-1:0]  w_start;
  logic [SEL_W-1:0]  w_next_ptr;
  logic [SEL_W:0]    w_cand;
  logic              w_found;
  logic [NUM_IN-1:0] w_rr_grant;
  logic [SEL_W-1:0]  w_rr_idx;

  // Walk channels starting at w_start, wrapping modulo NUM_IN; first requester wins.
  always_comb begin
    w_start    = (MODE == MODE_RR) ? r_ptr : '0;
    w_cand     = '0;
    w_found    = 1'b0;
    w_rr_idx   = '0;
    w_rr_grant = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      w_cand = {1'b0, w_start} + (SEL_W+1)'(i);
      if (w_cand >= (SEL_W+1)'(NUM_IN)) w_cand = w_cand - (SEL_W+1)'(NUM_IN);
      if (!w_found && req[w_cand[SEL_W-1:0]]) begin
        w_found  = 1'b1;
        w_rr_idx = w_cand[SEL_W-1:0];
      end
    end
    if (w_found) w_rr_grant = NUM_IN'(1) << w_rr_idx;
  end

  assign w_next_ptr = (grant_idx == SEL_W'(NUM_IN - 1)) ? '0 : grant_idx + 1'b1;

`ifdef RR_MUX_LOCK_EN
  logic             r_locked;
  logic [SEL_W-1:0] r_lock_idx;

  always_comb begin
    grant     = w_rr_grant;
    grant_idx = w_rr_idx;
    if (r_locked) begin
      grant_idx = r_lock_idx;
      grant     = req[r_lock_idx] ? (NUM_IN'(1) << r_lock_idx) : '0;
    end
  end

  // The pointer only moves when a packet completes, so a locked burst counts as one turn.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_ptr      <= '0;
      r_locked   <= 1'b0;
      r_lock_idx <= '0;
    end else if (advance) begin
      if (last) begin
        r_locked <= 1'b0;
        if (MODE == MODE_RR) r_ptr <= w_next_ptr;
      end else begin
        r_locked   <= 1'b1;
        r_lock_idx <= grant_idx;
      end
    end
  end
`else
  assign grant     = w_rr_grant;
  assign grant_idx = w_rr_idx;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_ptr <= '0;
    end else if (advance && (MODE == MODE_RR)) begin
      r_ptr <= w_next_ptr;
    end
  end
`endif

endmodule

// File: rtl/rr_mux.sv
// Registered NUM_IN:1 valid/ready multiplexer with an internal fixed-priority or round-robin arbiter.
// Define RR_MUX_LOCK_EN to add in_last/out_last and hold the grant for a whole packet.
module rr_mux
  import mux_pkg::*;
#(
  parameter  int WIDTH  = 32,
  parameter  int NUM_IN = 4,
  parameter  int MODE   = MODE_RR,
  localparam int SEL_W  = sel_width(NUM_IN)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [NUM_IN-1:0]       in_valid,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
`ifdef RR_MUX_LOCK_EN
  input  logic [NUM_IN-1:0]       in_last,
  output logic                    out_last,
`endif
  output logic [NUM_IN-1:0]       in_ready,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_sel
);

  logic              r_valid;
  logic [WIDTH-1:0]  r_data;
  logic [SEL_W-1:0]  r_sel;
  logic [NUM_IN-1:0] w_grant;
  logic [SEL_W-1:0]  w_grant_idx;
  logic              w_slot_free;
  logic              w_load;
  logic [WIDTH-1:0]  w_sel_data;

  rr_arbiter #(
    .NUM_IN (NUM_IN),
    .MODE   (MODE)
  ) u_arb (
    .clock     (clock),
    .reset     (reset),
    .req       (in_valid),
    .advance   (w_load),
`ifdef RR_MUX_LOCK_EN
    .last      (|(in_last & w_grant)),
`endif
    .grant     (w_grant),
    .grant_idx (w_grant_idx)
  );

  // A grant can be empty while requests exist only when a lock is held on an idle channel.
  assign w_slot_free = !r_valid || out_ready;
  assign w_load      = w_slot_free && (|w_grant) && !reset;
  assign in_ready    = w_load ? w_grant : '0;

  always_comb begin
    w_sel_data = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      w_sel_data = w_sel_data | ({WIDTH{w_grant[i]}} & in_data[i*WIDTH +: WIDTH]);
    end
  end

`ifdef RR_MUX_LOCK_EN
  logic r_last;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_last <= 1'b0;
    end else if (w_load) begin
      r_last <= |(in_last & w_grant);
    end
  end

  assign out_last = r_last;
`endif

  // Output register: load replaces the held beat, otherwise an accepted beat drains.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_sel   <= '0;
    end else if (w_load) begin
      r_valid <= 1'b1;
      r_data  <= w_sel_data;
      r_sel   <= w_grant_idx;
    end else if (out_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign out_valid = r_valid;
  assign out_data  = r_data;
  assign out_sel   = r_sel;

endmodule
